// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte/state types, forward and inverse S-box tables, inverse SubBytes FSM encoding
package aes_pkg;
  typedef logic [7:0] byte_t;
  typedef byte_t [15:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} inv_sb_fsm_t;
  localparam byte_t SBOX[256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam byte_t INV_SBOX[256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: one inverse S-box lane, LAT register stages carrying a valid bit and the group tag alongside the byte
module aes_inv_sbox
  import aes_pkg::*;
#(
  parameter int LAT = 1,
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v,
  input  byte_t         x,
  input  logic [TW-1:0] t,
  output logic          my_v,
  output byte_t         y,
  output logic [TW-1:0] my_t
);
  logic [LAT-1:0] vp;
  byte_t yp[LAT];
  logic [TW-1:0] tp[LAT];
  always_ff @(posedge clk) begin
    vp[0] <= v & ~rst;
    yp[0] <= INV_SBOX[x];
    tp[0] <= t;
    for (int i = 1; i < LAT; i++) begin
      vp[i] <= vp[i-1] & ~rst;
      yp[i] <= yp[i-1];
      tp[i] <= tp[i-1];
    end
  end
  assign my_v = vp[LAT-1];
  assign y = yp[LAT-1];
  assign my_t = tp[LAT-1];
endmodule

// File: rtl/aes_inv_sub_bytes.sv
// aes_inv_sub_bytes: inverse SubBytes over a 128-bit state, LANES bytes per cycle, valid/ready on both sides
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int NG = 16 / LANES;
  localparam int TW = NG > 1 ? $clog2(NG) : 1;
  localparam logic [TW-1:0] LAST = TW'(NG - 1);
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end
  if (SBOX_LAT < 1) begin : g_bad_lat
    $error("aes_inv_sub_bytes: SBOX_LAT must be at least 1");
  end
  inv_sb_fsm_t state;
  logic [TW-1:0] g;
  state_t work;
  logic [LANES-1:0] wv;
  byte_t wy[LANES];
  logic [TW-1:0] wt[LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox #(.LAT(SBOX_LAT), .TW(TW)) u_sbox (
      .clk(clk), .rst(rst), .v(state == RUN), .x(work[LANES * int'(g) + l]), .t(g),
      .my_v(wv[l]), .y(wy[l]), .my_t(wt[l])
    );
  end
  // writeback lands at the tagged group position, so lanes need not return in lockstep with the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      out_state <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (wv[i]) out_state[8 * (LANES * int'(wt[i]) + i) +: 8] <= wy[i];
      case (state)
        IDLE: if (in_valid && in_ready) begin
          work <= in_state;
          g <= '0;
          state <= RUN;
          in_ready <= 1'b0;
          busy <= 1'b1;
        end else in_ready <= 1'b1;
        RUN: begin
          g <= (g == LAST) ? '0 : g + 1'b1;
          if (g == LAST) state <= DRAIN;
        end
        DRAIN: if (wv[0] && wt[0] == LAST) begin
          state <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// tb_aes_inv_sub_bytes: randomized bench against a GF(2^8)-derived inverse S-box model, three LANES configurations
module tb_aes_inv_sub_bytes;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [2:0] iv, ir, ov, ordy, bsy;
  logic [127:0] din[3], dout[3], last_os[3];
  int outs[3] = '{0, 0, 0};
  int nv = 0, nerr = 0;
  logic [7:0] fwd_t[256], inv_t[256];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    nv++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_blk(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_t[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd_blk(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : 16;
    localparam int NG = 16 / L;
    aes_inv_sub_bytes #(.LANES(L), .SBOX_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[k]), .in_ready(ir[k]), .in_state(din[k]),
      .out_valid(ov[k]), .out_ready(ordy[k]), .out_state(dout[k]), .busy(bsy[k])
    );
    logic [127:0] q[$];
    logic [127:0] pos, exp_os;
    logic pov = 1'b0, phs = 1'b0;
    int c = 0, acc = 0;
    always @(negedge clk) begin
      c++;
      if (rst) begin
        q.delete();
        pov = 1'b0;
        phs = 1'b0;
      end else begin
        check("ready_while_busy", ir[k] & bsy[k], 1'b0);
        if (ov[k]) check("busy_in_done", bsy[k], 1'b1);
        if (ov[k] && pov && !phs) check("held_output", dout[k], pos);
        if (ov[k] && !pov) check("latency", c - 1 - acc, NG + 1);
        if (ov[k] && ordy[k]) begin
          if (q.size() == 0) check("spurious_out", ov[k], 1'b0);
          else begin
            exp_os = q.pop_front();
            check("out_state", dout[k], exp_os);
          end
          last_os[k] = dout[k];
          outs[k]++;
        end
        if (iv[k] && ir[k]) begin
          q.push_back(inv_blk(din[k]));
          acc = c;
        end
        pov = ov[k];
        phs = ov[k] & ordy[k];
        pos = dout[k];
      end
    end
  end

  task automatic send(input int k, input logic [127:0] d);
    int n = 0;
    din[k] = d;
    iv[k] = 1'b1;
    while (!ir[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", ir[k], 1'b1);
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    int c0 = outs[k];
    int n = 0;
    while (outs[k] == c0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("output_timeout", outs[k] != c0, 1'b1);
  endtask

  initial begin
    logic [127:0] d, d2;
    int n, n0;
    for (int x = 0; x < 256; x++) fwd_t[x] = affine(ginv(8'(x)));
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
    check("model_inv00", inv_t[8'h00], 8'h52);
    check("model_inv63", inv_t[8'h63], 8'h00);
    check("model_inv7c", inv_t[8'h7c], 8'h01);
    check("model_invff", inv_t[8'hff], 8'h7d);
    iv = '0;
    ordy = '1;
    for (int k = 0; k < 3; k++) din[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", ir[k], 1'b0);
      check("rst_out_valid", ov[k], 1'b0);
      check("rst_busy", bsy[k], 1'b0);
      check("rst_out_state", dout[k], '0);
    end
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", ir[0], 1'b1);
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * b + i);
      send(0, d);
      wait_out(0);
      if (b == 0) check("sweep_inv00", last_os[0][7:0], 8'h52);
      if (b == 6) check("sweep_inv63", last_os[0][31:24], 8'h00);
      if (b == 7) check("sweep_inv7c", last_os[0][103:96], 8'h01);
      if (b == 15) check("sweep_invff", last_os[0][127:120], 8'h7d);
    end
    for (int v = 0; v < 1000; v++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(0, fwd_blk(d));
      wait_out(0);
      check("round_trip", last_os[0], d);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    ordy[0] = 1'b0;
    send(0, d);
    n = 0;
    while (!ov[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid", ov[0], 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid_hold", ov[0], 1'b1);
      check("bp_busy", bsy[0], 1'b1);
    end
    n0 = outs[0];
    ordy[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("bp_one_transfer", outs[0] - n0, 1);
    check("bp_valid_after", ov[0], 1'b0);
    check("bp_result", last_os[0], inv_blk(d));
    d = {$urandom, $urandom, $urandom, $urandom};
    send(0, d);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("midrst_valid", ov[0], 1'b0);
    check("midrst_busy", bsy[0], 1'b0);
    rst = 0;
    n = 0;
    while (!ir[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_ready", ir[0], 1'b1);
    d2 = ~d;
    n0 = outs[0];
    send(0, d2);
    wait_out(0);
    check("midrst_count", outs[0] - n0, 1);
    check("midrst_result", last_os[0], inv_blk(d2));
    for (int k = 1; k < 3; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(k, d);
      wait_out(k);
      check("lanes_result", last_os[k], inv_blk(d));
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
